// File: rtl/psum_writeback_if.sv
// ---------------------------------------------------------------------------
// psum_writeback_if
// Bundles the two handshakes of the partial-sum writeback block:
//   - upstream sum hand-off : PS_rdy / PS_ack, i_sum (PEROW rows), i_d16
//   - psum buffer write bus : o_wr_en / i_wr_gnt, o_wr_addr, o_wr_data
// Signal names keep the block's own i_/o_ direction prefixes as seen from the
// writeback block.
// Modports:
//   master : the writeback block (drives PS_ack and the write bus)
//   slave  : the environment (upstream sum stage + psum buffer)
// ---------------------------------------------------------------------------
interface psum_writeback_if #(
    parameter int PEROW   = 4,
    parameter int PSUMDWD = 32,
    parameter int AWD     = 8
);
    logic                            PS_rdy;
    logic                            PS_ack;
    logic [PEROW-1:0][PSUMDWD-1:0]   i_sum;
    logic                            i_d16;
    logic                            o_wr_en;
    logic                            i_wr_gnt;
    logic [AWD-1:0]                  o_wr_addr;
    logic [PSUMDWD-1:0]              o_wr_data;

    modport master (
        input  PS_rdy, i_sum, i_d16, i_wr_gnt,
        output PS_ack, o_wr_en, o_wr_addr, o_wr_data
    );

    modport slave (
        output PS_rdy, i_sum, i_d16, i_wr_gnt,
        input  PS_ack, o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/psum_writeback.sv
// ---------------------------------------------------------------------------
// psum_writeback
// Accepts one set of PEROW saturated partial sums per transfer and writes them
// into the psum buffer as a burst of beats, one row per beat (D32) or two
// rows packed as 16-bit halves per beat (D16). A write pointer advances per
// granted beat and can be reloaded at any time.
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_rst        asynchronous active-low reset
//   bus          psum_writeback_if.master (sum hand-off + buffer write bus)
//   i_addr_load  load write pointer from i_base_addr (wins over increment)
//   i_base_addr  new write pointer value
//   o_done       one-cycle pulse the cycle after the last beat is granted
//   o_wr_cnt     granted-write counter (constant 0 unless enabled)
//
// Build option:
//   PSUM_WB_CNT_EN  when defined, o_wr_cnt counts granted beats, saturating at
//                   16'hFFFF and cleared by i_addr_load; otherwise no counter.
// ---------------------------------------------------------------------------
module psum_writeback #(
    parameter int PEROW   = 4,
    parameter int PSUMDWD = 32,
    parameter int AWD     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    psum_writeback_if.master bus,
    input  logic             i_addr_load,
    input  logic [AWD-1:0]   i_base_addr,
    output logic             o_done,
    output logic [15:0]      o_wr_cnt
);
    localparam int BW = (PEROW > 2) ? $clog2(PEROW) : 1;

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t             r_state;
    logic               r_wr_en;
    logic [BW-1:0]      r_beat;
    logic               r_d16;
    logic               r_done;
    logic [AWD-1:0]     r_ptr;
    logic [PSUMDWD-1:0] r_sum [PEROW];

    logic               w_fire;
    logic               w_last;
    logic               w_ack;
    logic               w_xfer;
    logic [BW-1:0]      w_last_idx;
    logic [PSUMDWD-1:0] w_d32;
    logic [31:0]        w_d16;

    assign w_last_idx = r_d16 ? BW'(PEROW/2 - 1) : BW'(PEROW - 1);
    assign w_fire     = r_wr_en && bus.i_wr_gnt;
    assign w_last     = w_fire && (r_beat == w_last_idx);
    // Ack in WRITE only alongside the granted last beat, so the next set of
    // sums can be captured without an idle bubble.
    assign w_ack      = (r_state == S_IDLE) || w_last;
    assign w_xfer     = bus.PS_rdy && w_ack;

    // FSM: capture on transfer, step beats on grant
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_wr_en <= 1'b0;
            r_beat  <= '0;
            r_d16   <= 1'b0;
            r_done  <= 1'b0;
            for (int k = 0; k < PEROW; k++) r_sum[k] <= '0;
        end else begin
            r_done <= w_last;
            if (w_xfer) begin
                for (int k = 0; k < PEROW; k++) r_sum[k] <= bus.i_sum[k];
                r_d16   <= bus.i_d16;
                r_beat  <= '0;
                r_state <= S_WRITE;
                r_wr_en <= 1'b1;
            end else if (w_fire) begin
                if (w_last) begin
                    r_state <= S_IDLE;
                    r_wr_en <= 1'b0;
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
        end
    end

    // Write pointer: load wins over the per-beat increment
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ptr <= '0;
        end else if (i_addr_load) begin
            r_ptr <= i_base_addr;
        end else if (w_fire) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // Beat data select from the captured sums only
    always_comb begin
        w_d32 = '0;
        w_d16 = '0;
        for (int k = 0; k < PEROW; k++) begin
            if (r_beat == BW'(k)) w_d32 = r_sum[k];
        end
        for (int k = 0; k < PEROW/2; k++) begin
            if (r_beat == BW'(k)) w_d16 = {r_sum[2*k+1][15:0], r_sum[2*k][15:0]};
        end
    end

    assign bus.PS_ack    = w_ack;
    assign bus.o_wr_en   = r_wr_en;
    assign bus.o_wr_addr = r_ptr;
    assign bus.o_wr_data = r_d16 ? PSUMDWD'(w_d16) : w_d32;
    assign o_done        = r_done;

`ifdef PSUM_WB_CNT_EN
    logic [15:0] r_wr_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_cnt <= '0;
        end else if (i_addr_load) begin
            r_wr_cnt <= '0;
        end else if (w_fire && (r_wr_cnt != 16'hFFFF)) begin
            r_wr_cnt <= r_wr_cnt + 16'd1;
        end
    end

    assign o_wr_cnt = r_wr_cnt;
`else
    assign o_wr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_psum_writeback.sv
// ---------------------------------------------------------------------------
// tb_psum_writeback
// Directed scenarios followed by random traffic; every cycle the outputs are
// compared with a queue-based reference model of the pending write beats.
// ---------------------------------------------------------------------------
module tb_psum_writeback;
    localparam int PEROW   = 4;
    localparam int PSUMDWD = 32;
    localparam int AWD     = 8;
    localparam int SW      = PEROW * PSUMDWD;

    logic           clk = 1'b0;
    logic           rst;
    logic           addr_load;
    logic [AWD-1:0] base_addr;
    logic           done;
    logic [15:0]    wr_cnt;

    psum_writeback_if #(.PEROW(PEROW), .PSUMDWD(PSUMDWD), .AWD(AWD)) bus ();

    psum_writeback #(.PEROW(PEROW), .PSUMDWD(PSUMDWD), .AWD(AWD)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .i_addr_load (addr_load),
        .i_base_addr (base_addr),
        .o_done      (done),
        .o_wr_cnt    (wr_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: beats still owed for the current transfer, pointer,
    // done pulse and granted-write count.
    logic [PSUMDWD-1:0] mq[$];
    logic [AWD-1:0]     mptr;
    logic               mdone;
    logic [15:0]        mcnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [SW-1:0] rsum();
        logic [SW-1:0] s;
        for (int k = 0; k < PEROW; k++) s[k*PSUMDWD +: PSUMDWD] = $urandom;
        return s;
    endfunction

    task automatic model_reset();
        mq.delete();
        mptr  = '0;
        mdone = 1'b0;
        mcnt  = '0;
    endtask

    task automatic check_outputs(input logic gnt);
        logic exp_ack;
        exp_ack = (mq.size() == 0) || (mq.size() == 1 && gnt);
        check("ps_ack", 64'(bus.PS_ack), 64'(exp_ack));
        check("wr_en", 64'(bus.o_wr_en), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("wr_addr", 64'(bus.o_wr_addr), 64'(mptr));
            check("wr_data", 64'(bus.o_wr_data), 64'(mq[0]));
        end
        check("done", 64'(done), 64'(mdone));
`ifdef PSUM_WB_CNT_EN
        check("wr_cnt", 64'(wr_cnt), 64'(mcnt));
`else
        check("wr_cnt", 64'(wr_cnt), 64'h0);
`endif
    endtask

    task automatic model_advance(input logic rdy, input logic d16, input logic [SW-1:0] sum,
                                 input logic gnt, input logic ld, input logic [AWD-1:0] base);
        logic fire, ack, xfer;
        logic [PSUMDWD-1:0] w;
        fire  = (mq.size() != 0) && gnt;
        ack   = (mq.size() == 0) || (mq.size() == 1 && gnt);
        xfer  = rdy && ack;
        mdone = fire && (mq.size() == 1);
        if (fire) mq.delete(0);
        if (xfer) begin
            if (!d16) begin
                for (int k = 0; k < PEROW; k++) mq.push_back(sum[k*PSUMDWD +: PSUMDWD]);
            end else begin
                for (int k = 0; k < PEROW/2; k++) begin
                    w        = '0;
                    w[15:0]  = sum[(2*k)*PSUMDWD +: 16];
                    w[31:16] = sum[(2*k+1)*PSUMDWD +: 16];
                    mq.push_back(w);
                end
            end
        end
        if (ld)        mptr = base;
        else if (fire) mptr = mptr + 1'b1;
        if (ld)                          mcnt = '0;
        else if (fire && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    endtask

    // One clock: drive at negedge, check just after, advance model.
    task automatic cycle(input logic rdy, input logic d16, input logic [SW-1:0] sum,
                         input logic gnt, input logic ld, input logic [AWD-1:0] base);
        @(negedge clk);
        bus.PS_rdy   = rdy;
        bus.i_d16    = d16;
        bus.i_sum    = sum;
        bus.i_wr_gnt = gnt;
        addr_load    = ld;
        base_addr    = base;
        #1;
        check_outputs(gnt);
        model_advance(rdy, d16, sum, gnt, ld, base);
    endtask

    initial begin
        rst          = 1'b1;
        bus.PS_rdy   = 1'b0;
        bus.i_d16    = 1'b0;
        bus.i_sum    = '0;
        bus.i_wr_gnt = 1'b0;
        addr_load    = 1'b0;
        base_addr    = '0;
        model_reset();
        #2 rst = 1'b0;
        #1;
        check_outputs(1'b0);
        check("rst_addr", 64'(bus.o_wr_addr), 64'h0);
        check("rst_data", 64'(bus.o_wr_data), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // D32 burst from base 0x10, grant always
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 8'h10);
        cycle(1'b1, 1'b0, pack4(32'd1, 32'd2, 32'd3, 32'd4), 1'b1, 1'b0, 8'h00);
        @(posedge clk); #1;
        check("d32_beat0_addr", 64'(bus.o_wr_addr), 64'h10);
        check("d32_beat0_data", 64'(bus.o_wr_data), 64'h1);
        repeat (4) cycle(1'b0, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h00);

        // D16 packing
        cycle(1'b1, 1'b1, pack4(32'h0001_AAAA, 32'h0002_BBBB, 32'h0003_CCCC, 32'h0004_DDDD),
              1'b1, 1'b0, 8'h00);
        @(posedge clk); #1;
        check("d16_beat0_data", 64'(bus.o_wr_data), 64'hBBBB_AAAA);
        repeat (3) cycle(1'b0, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);

        // Grant withheld for 3 cycles on beat 1
        cycle(1'b1, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);
        repeat (3) cycle(1'b1, 1'b0, rsum(), 1'b0, 1'b0, 8'h00);
        repeat (3) cycle(1'b0, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);

        // Back-to-back: PS_rdy held through the last granted beat
        cycle(1'b1, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);
        repeat (4) cycle(1'b1, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);
        repeat (5) cycle(1'b0, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);

        // Pointer wrap from 0xFE, reload during beat 2
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 8'hFE);
        cycle(1'b1, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, rsum(), 1'b1, 1'b1, 8'h40);
        cycle(1'b0, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);

        // Reset during beat 2
        cycle(1'b1, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b1);
        check("midrst_addr", 64'(bus.o_wr_addr), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, rsum(), 1'b1, 1'b0, 8'h00);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rsum(),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                  AWD'($urandom));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/psum_writeback.md
PSUM_WRITEBACK -- requirements
Module: psum_writeback

Interface
REQ-001 SHALL have parameter PEROW, default 4, number of PE rows (even, >=2).
REQ-002 SHALL have parameter PSUMDWD, default 32, partial-sum width.
REQ-003 SHALL have parameter AWD, default 8, psum buffer address width.
REQ-004 i_clk  input  1  sole clock; all state on rising edge.
REQ-005 i_rst  input  1  reset; asynchronous, active-low.
REQ-006 PS_rdy  input  1  upstream sum stage holds valid sums.
REQ-007 PS_ack  output  1  transfer accepted; a transfer occurs when PS_rdy && PS_ack.
REQ-008 i_sum  input  PEROW x PSUMDWD  per-row saturated sums, sampled on transfer.
REQ-009 i_d16  input  1  16-bit packing mode, sampled on transfer.
REQ-010 i_addr_load  input  1  load write pointer from i_base_addr.
REQ-011 i_base_addr  input  AWD  new write pointer value.
REQ-012 o_wr_en  output  1  buffer write request.
REQ-013 i_wr_gnt  input  1  buffer accepts the write this cycle.
REQ-014 o_wr_addr  output  AWD  write address.
REQ-015 o_wr_data  output  PSUMDWD  write data.
REQ-016 o_done  output  1  one-cycle pulse after the last beat of a transfer is granted.
REQ-017 o_wr_cnt  output  16  granted-write counter (see Configuration).

Function
REQ-018 SHALL implement two states: IDLE and WRITE.
REQ-019 IDLE: PS_ack=1, o_wr_en=0; on transfer, capture i_sum and i_d16 into internal registers, beat index=0, go to WRITE.
REQ-020 WRITE: o_wr_en=1; beat advances only on o_wr_en && i_wr_gnt; o_wr_en held with stable addr/data while i_wr_gnt=0.
REQ-021 D32 mode (captured i_d16=0): PEROW beats; beat k data = row k sum.
REQ-022 D16 mode: PEROW/2 beats; beat k data = {row 2k+1 [15:0], row 2k [15:0]}.
REQ-023 o_wr_addr = write pointer; pointer increments by 1 per granted beat, wraps from 2^AWD-1 to 0.
REQ-024 PS_ack in WRITE SHALL be 1 only in the cycle of a granted last beat; a transfer then recaptures and stays in WRITE with beat=0 (zero-bubble back-to-back); otherwise go to IDLE.
REQ-025 o_done SHALL be registered, asserting the cycle after a granted last beat.
REQ-026 i_addr_load SHALL take priority over the increment in the same cycle; loaded value applies to the next beat.
REQ-027 Input sums SHALL NOT be read outside the transfer cycle; upstream may change i_sum after acknowledgement.
REQ-028 Latency: first o_wr_en one cycle after transfer; D32 with constant grant occupies PEROW cycles.

Reset
REQ-029 On i_rst low, asynchronously: state=IDLE, PS_ack=1 (combinational from IDLE), o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_done=0, o_wr_cnt=0, captured sums cleared.
REQ-030 Reset mid-WRITE SHALL abandon remaining beats without any further write.

Configuration
REQ-031 Macro PSUM_WB_CNT_EN defined: o_wr_cnt increments by 1 per granted beat, saturating at 16'hFFFF, cleared by i_addr_load.
REQ-032 PSUM_WB_CNT_EN undefined: o_wr_cnt SHALL be constant 0, no counter flops.

Verification
REQ-033 D32, PEROW=4, base 8'h10, sums {1,2,3,4}, grant always -> writes (10,1),(11,2),(12,3),(13,4), o_done next cycle.
REQ-034 D16, sums {0x0001_AAAA,..,0x0004_DDDD} -> two writes 0xBBBB_AAAA, 0xDDDD_CCCC at consecutive addresses.
REQ-035 Grant low 3 cycles on beat 1 -> addr/data of beat 1 held stable, no skip, PS_ack stays 0.
REQ-036 PS_rdy held during last granted beat -> PS_ack=1 that cycle, next transfer's beat 0 the following cycle with no bubble.
REQ-037 Base 8'hFE, D32 -> addresses FE,FF,00,01; i_addr_load during beat 2 redirects beat 3.
REQ-038 i_rst low during beat 2 -> o_wr_en 0 immediately, IDLE, pointer 0; with PSUM_WB_CNT_EN o_wr_cnt=0.
